// File: rtl/uw_frame_inserter.sv
// QPSK transmit framer: emits UW_LEN unique-word symbols followed by PAYLOAD_LEN payload
// dibits as signed I/Q samples. Define TX_PHASE_ROT_EN to add per-frame 90-degree rotation (rot_sel).
module uw_frame_inserter #(
    parameter int UW_LEN      = 16,
    parameter int PAYLOAD_LEN = 16368,
    parameter int AMP         = 8192
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2*UW_LEN-1:0]   uw_pattern,
`ifdef TX_PHASE_ROT_EN
    input  logic [1:0]            rot_sel,
`endif
    input  logic [1:0]            pay_data,
    input  logic                  pay_valid,
    output logic                  pay_ready,
    output logic [15:0]           out_i,
    output logic [15:0]           out_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [13:0]           sym_index,
    output logic                  uw_flag,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  underrun
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // out_valid/out_i/out_q stay stable while out_valid && !out_ready.
    typedef enum logic [1:0] {S_IDLE, S_UW, S_PAYLOAD} state_t;

    localparam logic [14:0] TOTAL_C = 15'(UW_LEN + PAYLOAD_LEN);
    localparam logic [14:0] LAST_UW = 15'(UW_LEN - 1);
    localparam logic [15:0] AMP_P   = 16'(AMP);
    localparam logic [15:0] AMP_N   = 16'(-AMP);

    state_t              state, next_state;
    logic [14:0]         cnt;
    logic [2*UW_LEN-1:0] uw_r;
    logic                slot_free, all_loaded;
    logic                load_first, load_uw, load_pay, last_acc;
    logic [1:0]          sym;
    logic [15:0]         map_i, map_q, nxt_i, nxt_q;
`ifdef TX_PHASE_ROT_EN
    logic [1:0]          rot_r, rot_use;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        slot_free  = !out_valid || out_ready;
        all_loaded = (cnt == TOTAL_C);
        load_first = (state == S_IDLE) && start;
        load_uw    = (state == S_UW) && slot_free;
        pay_ready  = (state == S_PAYLOAD) && !all_loaded && slot_free;
        load_pay   = pay_ready && pay_valid;
        underrun   = (state == S_PAYLOAD) && !all_loaded && slot_free && !pay_valid;
        last_acc   = (state == S_PAYLOAD) && all_loaded && out_valid && out_ready;
        case (state)
            S_IDLE:    if (start) next_state = (LAST_UW == 15'd0) ? S_PAYLOAD : S_UW;
            S_UW:      if (load_uw && cnt == LAST_UW) next_state = S_PAYLOAD;
            S_PAYLOAD: if (last_acc) next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // The first UW symbol comes straight from the port so it lands one cycle after start.
    always_comb begin
        if (load_first)   sym = uw_pattern[2*UW_LEN-1 -: 2];
        else if (load_uw) sym = uw_r[2*UW_LEN-1 -: 2];
        else              sym = pay_data;
        map_i = sym[1] ? AMP_N : AMP_P;
        map_q = sym[0] ? AMP_N : AMP_P;
        nxt_i = map_i;
        nxt_q = map_q;
`ifdef TX_PHASE_ROT_EN
        rot_use = load_first ? rot_sel : rot_r;
        case (rot_use)
            2'd1:    begin nxt_i = -map_q; nxt_q = map_i;  end
            2'd2:    begin nxt_i = -map_i; nxt_q = -map_q; end
            2'd3:    begin nxt_i = map_q;  nxt_q = -map_i; end
            default: begin nxt_i = map_i;  nxt_q = map_q;  end
        endcase
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            uw_r       <= '0;
            out_i      <= '0;
            out_q      <= '0;
            out_valid  <= 1'b0;
            sym_index  <= '0;
            uw_flag    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef TX_PHASE_ROT_EN
            rot_r      <= 2'd0;
`endif
        end else begin
            frame_done <= 1'b0;
            if (load_first || load_uw || load_pay) begin
                out_valid <= 1'b1;
                out_i     <= nxt_i;
                out_q     <= nxt_q;
                uw_flag   <= load_first || load_uw;
                sym_index <= load_first ? 14'd0 : cnt[13:0];
                cnt       <= load_first ? 15'd1 : cnt + 15'd1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (load_first) begin
                uw_r <= uw_pattern << 2;
                busy <= 1'b1;
`ifdef TX_PHASE_ROT_EN
                rot_r <= rot_sel;
`endif
            end else if (load_uw) begin
                uw_r <= uw_r << 2;
            end
            if (last_acc) begin
                busy       <= 1'b0;
                frame_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uw_frame_inserter.sv
// Bench for uw_frame_inserter: directed and random frames checked against a
// transaction-level model (expected sample list, load/accept counts).
module tb_uw_frame_inserter;
    localparam int UW_LEN      = 16;
    localparam int PAYLOAD_LEN = 8;
    localparam int TOTAL       = UW_LEN + PAYLOAD_LEN;
    localparam int AMP         = 8192;

    logic        clk = 1'b0;
    logic        rst_n, start, pay_valid, pay_ready, out_valid, out_ready;
    logic [31:0] uw_pattern;
    logic [1:0]  pay_data, rot_sel;
    logic [15:0] out_i, out_q;
    logic [13:0] sym_index;
    logic        uw_flag, busy, frame_done, underrun;

    int total = 0;
    int bad   = 0;

    // model state
    logic [31:0] exp_q[$];
    int          loaded = 0, accepted = 0, unders = 0;
    bit          busy_exp = 0, done_exp = 0;

    always #5 clk = ~clk;

    uw_frame_inserter #(.UW_LEN(UW_LEN), .PAYLOAD_LEN(PAYLOAD_LEN), .AMP(AMP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .uw_pattern(uw_pattern),
`ifdef TX_PHASE_ROT_EN
        .rot_sel(rot_sel),
`endif
        .pay_data(pay_data), .pay_valid(pay_valid), .pay_ready(pay_ready),
        .out_i(out_i), .out_q(out_q), .out_valid(out_valid), .out_ready(out_ready),
        .sym_index(sym_index), .uw_flag(uw_flag), .busy(busy),
        .frame_done(frame_done), .underrun(underrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // QPSK point for a dibit, then multiplied by j^r.
    function automatic logic [31:0] model_sym(input logic [1:0] d, input logic [1:0] r);
        int re, im, t;
        re = d[1] ? -AMP : AMP;
        im = d[0] ? -AMP : AMP;
        for (int k = 0; k < int'(r); k++) begin
            t  = re;
            re = -im;
            im = t;
        end
        return {re[15:0], im[15:0]};
    endfunction

    // Checks outputs at the falling edge, then advances the model across the rising edge.
    task automatic cycle();
        bit         ov_exp, slot, in_pay, pr_exp, acc;
        logic [1:0] r;
        @(negedge clk);
        ov_exp = busy_exp && (loaded > accepted);
        slot   = !ov_exp || out_ready;
        in_pay = busy_exp && loaded >= UW_LEN && loaded < TOTAL;
        pr_exp = in_pay && slot;
        check("out_valid",  32'(out_valid),  32'(ov_exp));
        check("busy",       32'(busy),       32'(busy_exp));
        check("frame_done", 32'(frame_done), 32'(done_exp));
        check("pay_ready",  32'(pay_ready),  32'(pr_exp));
        check("underrun",   32'(underrun),   32'(pr_exp && !pay_valid));
        if (underrun === 1'b1) unders++;
        if (ov_exp) begin
            check("sample",    {out_i, out_q},    exp_q[accepted]);
            check("sym_index", 32'(sym_index),    32'(accepted));
            check("uw_flag",   32'(uw_flag),      32'(accepted < UW_LEN));
        end
        if (!rst_n) begin
            busy_exp = 0; done_exp = 0; loaded = 0; accepted = 0;
            exp_q.delete();
        end else begin
            done_exp = 0;
            acc = ov_exp && out_ready;
            if (!busy_exp) begin
                if (start) begin
`ifdef TX_PHASE_ROT_EN
                    r = rot_sel;
`else
                    r = 2'd0;
`endif
                    exp_q.delete();
                    for (int k = 0; k < UW_LEN; k++)
                        exp_q.push_back(model_sym(2'((uw_pattern >> (30 - 2 * k)) & 32'd3), r));
                    busy_exp = 1; loaded = 1; accepted = 0;
                end
            end else begin
                r = 2'd0;
`ifdef TX_PHASE_ROT_EN
                r = dut.rot_r;
`endif
                if (loaded < UW_LEN && slot) loaded++;
                else if (pr_exp && pay_valid) begin
                    exp_q.push_back(model_sym(pay_data, r));
                    loaded++;
                end
                if (acc) begin
                    accepted++;
                    if (accepted == TOTAL) begin busy_exp = 0; done_exp = 1; end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // mode 0: continuous, dibits 0,1,2,3..; 1: random handshakes; 2: stall+gap+stray start; 3: reset at index 10
    task automatic run_frame(input logic [31:0] pat, input logic [1:0] rot, input int mode);
        int n = 0, stall_left = 0, gap_left = 0;
        bit stall_done = 0, gap_done = 0;
        uw_pattern = pat; rot_sel = rot;
        start = 1; out_ready = 1; pay_valid = 1; pay_data = 2'd0; unders = 0;
        cycle();
        start = 0;
        while (busy_exp && n < 600) begin
            n++;
            out_ready = 1; pay_valid = 1;
            if (mode == 1) begin
                out_ready = ($urandom_range(0, 3) != 0);
                pay_valid = ($urandom_range(0, 3) != 0);
            end
            pay_data = (mode == 0) ? 2'((loaded - UW_LEN) & 3) : 2'($urandom_range(0, 3));
            if (mode == 2) begin
                if (!stall_done && loaded == UW_LEN + 3) begin stall_done = 1; stall_left = 5; end
                if (stall_done && !gap_done && stall_left == 0 && loaded == UW_LEN + 5) begin
                    gap_done = 1; gap_left = 3;
                end
                out_ready = (stall_left == 0);
                if (stall_left > 0) stall_left--;
                pay_valid = (gap_left == 0);
                start     = (gap_left == 3);
                if (gap_left > 0) gap_left--;
            end
            if (mode == 3 && loaded > accepted && accepted == 10) begin
                rst_n = 0;
                cycle();
                rst_n = 1;
                check("rst_out_valid", 32'(out_valid), 32'd0);
                check("rst_busy",      32'(busy),      32'd0);
                check("rst_sym_index", 32'(sym_index), 32'd0);
                break;
            end
            cycle();
        end
        check("frame_timeout", 32'(n >= 600), 32'd0);
        start = 0; out_ready = 1; pay_valid = 0;
        cycle();
        if (mode == 2) check("underrun_count", 32'(unders), 32'd3);
    endtask

    initial begin
        rst_n = 0; start = 0; out_ready = 1; pay_valid = 0; pay_data = 2'd0;
        uw_pattern = 32'd0; rot_sel = 2'd0;
        cycle();
        cycle();
        check("reset_out_i",     32'(out_i),     32'd0);
        check("reset_out_q",     32'(out_q),     32'd0);
        check("reset_sym_index", 32'(sym_index), 32'd0);
        check("reset_uw_flag",   32'(uw_flag),   32'd0);
        rst_n = 1;
        cycle();

        run_frame(32'h1B1B_1B1B, 2'd0, 0);
        run_frame($urandom, 2'd0, 2);
        for (int f = 0; f < 3; f++) run_frame($urandom, 2'd0, 1);
        run_frame($urandom, 2'd0, 3);
        run_frame($urandom, 2'd0, 1);
`ifdef TX_PHASE_ROT_EN
        run_frame(32'h0000_0000, 2'd1, 0);
        for (int f = 0; f < 2; f++) run_frame($urandom, 2'($urandom_range(0, 3)), 1);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
